// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the SRAM controller.
//   state_e     - access sequencer states (idle, low half, high half, done)
//   DATA_W      - pipeline data width (32)
//   HALF_W      - SRAM data width (16)
//   DEF_*       - default parameter values used by sram_ctrl and sram_ctrl_if
package sram_ctrl_pkg;

    localparam int unsigned DATA_W           = 32;
    localparam int unsigned HALF_W           = 16;
    localparam int unsigned DEF_WAIT_CYCLES  = 2;
    localparam int unsigned DEF_BASE_ADDR    = 1024;
    localparam int unsigned DEF_SRAM_AW      = 18;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLo   = 2'd1,
        StHi   = 2'd2,
        StDone = 2'd3
    } state_e;

    // Width of a counter able to hold 0..n-1 (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: MEM-stage request bus plus SRAM pad signals.
//   master modport: pipeline/board side (drives requests and sram_dq_in)
//   slave  modport: sram_ctrl side (drives rd_data, ready and the SRAM pins)
//   Requests: wr_en, rd_en, address[31:0], st_val[31:0]
//   Response: rd_data[31:0], ready
//   SRAM:     sram_addr[SRAM_AW-1:0], sram_dq_out/in[15:0], sram_dq_oe, sram_we_n, sram_oe_n
interface sram_ctrl_if #(
    parameter int unsigned SRAM_AW = sram_ctrl_pkg::DEF_SRAM_AW
) ();

    logic                              wr_en;
    logic                              rd_en;
    logic [sram_ctrl_pkg::DATA_W-1:0]  address;
    logic [sram_ctrl_pkg::DATA_W-1:0]  st_val;
    logic [sram_ctrl_pkg::DATA_W-1:0]  rd_data;
    logic                              ready;
    logic [SRAM_AW-1:0]                sram_addr;
    logic [sram_ctrl_pkg::HALF_W-1:0]  sram_dq_out;
    logic [sram_ctrl_pkg::HALF_W-1:0]  sram_dq_in;
    logic                              sram_dq_oe;
    logic                              sram_we_n;
    logic                              sram_oe_n;

    modport master (
        output wr_en, rd_en, address, st_val, sram_dq_in,
        input  rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

    modport slave (
        input  wr_en, rd_en, address, st_val, sram_dq_in,
        output rd_data, ready, sram_addr, sram_dq_out, sram_dq_oe, sram_we_n, sram_oe_n
    );

endinterface

// File: rtl/sram_wait_counter.sv
// sram_wait_counter: loadable down-counter with terminal flag, one per half-word access.
//   clk, rst      - clock, asynchronous active-high reset
//   i_load        - load i_load_val (has priority over counting)
//   i_load_val    - value loaded on i_load
//   i_en          - decrement while non-zero
//   o_count       - current count
//   o_done        - count is zero (last cycle of the half)
module sram_wait_counter #(
    parameter int unsigned CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_count,
    output logic             o_done
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign o_count = r_count;
    assign o_done  = (r_count == '0);

endmodule

// File: rtl/sram_ctrl.sv
// sram_ctrl: splits 32-bit MEM-stage loads/stores into two 16-bit asynchronous SRAM accesses
// (low half at {idx,0}, high half at {idx,1}), holding ready low while an access is in flight.
//   clk, rst - clock, asynchronous active-high reset
//   bus      - sram_ctrl_if.slave: request/response and SRAM pad signals
//   Optional (macro SRAM_CTRL_STATS_EN): stat_accesses, stat_stall_cycles saturating counters.
module sram_ctrl import sram_ctrl_pkg::*; #(
    parameter int unsigned WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int unsigned BASE_ADDR   = DEF_BASE_ADDR,
    parameter int unsigned SRAM_AW     = DEF_SRAM_AW
) (
    input  logic        clk,
    input  logic        rst,
    sram_ctrl_if.slave  bus
`ifdef SRAM_CTRL_STATS_EN
    ,
    output logic [31:0] stat_accesses,
    output logic [31:0] stat_stall_cycles
`endif
);

    localparam int unsigned CW = cnt_width(WAIT_CYCLES);
    localparam int unsigned IW = SRAM_AW - 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);
    // A one-cycle half is entirely its own hold cycle, so we_n never drops.
    localparam logic ONE_CYCLE = (WAIT_CYCLES == 1);

    state_e              r_state;
    logic                r_is_wr;
    logic [IW-1:0]       r_idx;
    logic [HALF_W-1:0]   r_st_hi;
    logic [DATA_W-1:0]   r_rd_data;
    logic [SRAM_AW-1:0]  r_sram_addr;
    logic [HALF_W-1:0]   r_dq_out;
    logic                r_dq_oe;
    logic                r_we_n;
    logic                r_oe_n;

    logic                w_req;
    logic [IW-1:0]       w_idx;
    logic                w_load;
    logic                w_cnt_en;
    logic [CW-1:0]       w_cnt;
    logic                w_cnt_done;
    logic                w_ready;

    assign w_req    = bus.wr_en | bus.rd_en;
    assign w_idx    = IW'((bus.address - BASE_ADDR) >> 2);
    assign w_load   = ((r_state == StIdle) && w_req) || ((r_state == StLo) && w_cnt_done);
    assign w_cnt_en = (r_state == StLo) || (r_state == StHi);

    sram_wait_counter #(
        .CNT_W (CW)
    ) u_wait_counter (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (CNT_LOAD),
        .i_en       (w_cnt_en),
        .o_count    (w_cnt),
        .o_done     (w_cnt_done)
    );

    // Outputs are registered, so each branch sets the pin values for the coming cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= StIdle;
            r_is_wr     <= 1'b0;
            r_idx       <= '0;
            r_st_hi     <= '0;
            r_rd_data   <= '0;
            r_sram_addr <= '0;
            r_dq_out    <= '0;
            r_dq_oe     <= 1'b0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b1;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_req) begin
                        r_state     <= StLo;
                        r_is_wr     <= bus.wr_en;   // write wins over read
                        r_idx       <= w_idx;
                        r_st_hi     <= bus.st_val[DATA_W-1:HALF_W];
                        r_sram_addr <= {w_idx, 1'b0};
                        r_dq_out    <= bus.st_val[HALF_W-1:0];
                        r_dq_oe     <= bus.wr_en;
                        r_we_n      <= !bus.wr_en || ONE_CYCLE;
                        r_oe_n      <= bus.wr_en;
                    end
                end
                StLo: begin
                    if (w_cnt_done) begin
                        r_state     <= StHi;
                        r_sram_addr <= {r_idx, 1'b1};
                        r_dq_out    <= r_st_hi;
                        r_we_n      <= !r_is_wr || ONE_CYCLE;
                        if (!r_is_wr) begin
                            r_rd_data[HALF_W-1:0] <= bus.sram_dq_in;
                        end
                    end else begin
                        // Release we_n for the final cycle so data is held past the rising edge.
                        r_we_n <= !r_is_wr || (w_cnt == CW'(1));
                    end
                end
                StHi: begin
                    if (w_cnt_done) begin
                        r_state     <= StDone;
                        r_sram_addr <= '0;
                        r_dq_out    <= '0;
                        r_dq_oe     <= 1'b0;
                        r_we_n      <= 1'b1;
                        r_oe_n      <= 1'b1;
                        if (!r_is_wr) begin
                            r_rd_data[DATA_W-1:HALF_W] <= bus.sram_dq_in;
                        end
                    end else begin
                        r_we_n <= !r_is_wr || (w_cnt == CW'(1));
                    end
                end
                StDone: begin
                    // The pipeline advances on this edge; its still-asserted request is ignored.
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Combinational in IDLE so the freeze covers the request's first cycle.
    always_comb begin
        w_ready = 1'b0;
        unique case (r_state)
            StIdle:  w_ready = !w_req;
            StDone:  w_ready = 1'b1;
            default: w_ready = 1'b0;
        endcase
    end

    assign bus.ready       = w_ready;
    assign bus.rd_data     = r_rd_data;
    assign bus.sram_addr   = r_sram_addr;
    assign bus.sram_dq_out = r_dq_out;
    assign bus.sram_dq_oe  = r_dq_oe;
    assign bus.sram_we_n   = r_we_n;
    assign bus.sram_oe_n   = r_oe_n;

`ifdef SRAM_CTRL_STATS_EN
    logic [31:0] r_stat_acc;
    logic [31:0] r_stat_stall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_acc   <= '0;
            r_stat_stall <= '0;
        end else begin
            if ((r_state == StDone) && (r_stat_acc != '1)) begin
                r_stat_acc <= r_stat_acc + 32'd1;
            end
            if (!w_ready && (r_stat_stall != '1)) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign stat_accesses     = r_stat_acc;
    assign stat_stall_cycles = r_stat_stall;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: directed bench for sram_ctrl (WAIT_CYCLES=2, BASE_ADDR=1024, SRAM_AW=18).
// A cycle-offset model predicts every output each cycle; literal checks pin the model.
// Stats checks are compiled in when SRAM_CTRL_STATS_EN is defined.
module tb_sram_ctrl;

    localparam int W = 2;
    localparam int N = 2 * W + 2;   // cycles recorded per access: request .. done

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if #(.SRAM_AW(18)) bus ();

`ifdef SRAM_CTRL_STATS_EN
    logic [31:0] stat_accesses;
    logic [31:0] stat_stall_cycles;
`endif

    sram_ctrl #(
        .WAIT_CYCLES (W),
        .BASE_ADDR   (1024),
        .SRAM_AW     (18)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .bus  (bus)
`ifdef SRAM_CTRL_STATS_EN
        ,
        .stat_accesses     (stat_accesses),
        .stat_stall_cycles (stat_stall_cycles)
`endif
    );

    int errors = 0;
    int checks = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // SRAM pad model: writes sampled on the clock while we_n is low, reads combinational.
    logic [15:0] mem [64];
    bit          mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) mem[i] <= 16'h0;
            mem[2]   <= 16'h5678;
            mem[3]   <= 16'h1234;
            mem_init <= 1'b1;
        end else if (!bus.sram_we_n) begin
            mem[bus.sram_addr[5:0]] <= bus.sram_dq_out;
        end
    end
    assign bus.sram_dq_in = bus.sram_oe_n ? 16'h0 : mem[bus.sram_addr[5:0]];

    // Model: t = cycle offset within an access (0 = request cycle, 1..W low half,
    // W+1..2W high half, 2W+1 done), -1 when idle.
    int          t = -1;
    bit          m_wr;
    int          m_idx;
    logic [31:0] m_data;
    logic [31:0] m_rd = 32'h0;
    logic [15:0] exp_mem [64];
    bit          m_init = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            t    = -1;
            m_rd = 32'h0;
            if (!m_init) begin
                for (int i = 0; i < 64; i++) exp_mem[i] = 16'h0;
                exp_mem[2] = 16'h5678;
                exp_mem[3] = 16'h1234;
                m_init = 1'b1;
            end
        end else if (t == -1) begin
            if (bus.wr_en || bus.rd_en) begin
                t      = 1;
                m_wr   = bus.wr_en;
                m_idx  = int'((bus.address - 32'd1024) >> 2);
                m_data = bus.st_val;
            end
        end else begin
            // A write commits in the cycles before each half's hold cycle.
            if (m_wr && t >= 1 && t < W)         exp_mem[(2 * m_idx) % 64]     = m_data[15:0];
            if (m_wr && t > W && t < 2 * W)      exp_mem[(2 * m_idx + 1) % 64] = m_data[31:16];
            if (!m_wr && t == W)                 m_rd[15:0]  = exp_mem[(2 * m_idx) % 64];
            if (!m_wr && t == 2 * W)             m_rd[31:16] = exp_mem[(2 * m_idx + 1) % 64];
            t = (t == 2 * W + 1) ? -1 : t + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            logic        e_ready, e_dqoe, e_we, e_oe;
            logic [31:0] e_addr, e_dq;
            e_ready = (t == -1) ? !(bus.wr_en || bus.rd_en) : (t == 2 * W + 1);
            e_addr = 32'h0; e_dq = 32'h0; e_dqoe = 1'b0; e_we = 1'b1; e_oe = 1'b1;
            if (t >= 1 && t <= 2 * W) begin
                e_addr = 32'(2 * m_idx + ((t > W) ? 1 : 0)) & 32'h3FFFF;
                e_dq   = (t > W) ? {16'h0, m_data[31:16]} : {16'h0, m_data[15:0]};
                e_dqoe = m_wr;
                e_we   = !m_wr || (t == W) || (t == 2 * W);
                e_oe   = m_wr;
            end
            chk("ready",     {31'h0, bus.ready},      {31'h0, e_ready});
            chk("rd_data",   bus.rd_data,             m_rd);
            chk("sram_addr", {14'h0, bus.sram_addr},  e_addr);
            chk("dq_out",    {16'h0, bus.sram_dq_out}, e_dq);
            chk("dq_oe",     {31'h0, bus.sram_dq_oe}, {31'h0, e_dqoe});
            chk("we_n",      {31'h0, bus.sram_we_n},  {31'h0, e_we});
            chk("oe_n",      {31'h0, bus.sram_oe_n},  {31'h0, e_oe});
        end
    end

    // Per-access trace for literal checks.
    logic        rec_ready [N];
    logic        rec_we    [N];
    logic        rec_oe    [N];
    logic [17:0] rec_addr  [N];
    logic [15:0] rec_dq    [N];
    logic [31:0] rec_rd    [N];

    task automatic run_access(input logic wr, input logic rd, input logic [31:0] a,
                              input logic [31:0] d);
        bus.wr_en = wr; bus.rd_en = rd; bus.address = a; bus.st_val = d;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            rec_ready[i] = bus.ready;   rec_we[i] = bus.sram_we_n; rec_oe[i] = bus.sram_oe_n;
            rec_addr[i]  = bus.sram_addr; rec_dq[i] = bus.sram_dq_out; rec_rd[i] = bus.rd_data;
        end
        @(posedge clk); #1;
    endtask

    task automatic go_idle(input int cycles);
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'h0; bus.st_val = 32'h0;
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    initial begin
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.address = 32'h0; bus.st_val = 32'h0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk_en = 1'b1;
        chk("reset rd_data", bus.rd_data, 32'h0);
        chk("reset ready",   {31'h0, bus.ready}, 32'h1);
        chk("reset we_n",    {31'h0, bus.sram_we_n}, 32'h1);
        chk("reset oe_n",    {31'h0, bus.sram_oe_n}, 32'h1);
        chk("reset addr",    {14'h0, bus.sram_addr}, 32'h0);
        @(posedge clk); #1;

        // Write 0xDEADBEEF at 1024.
        run_access(1'b1, 1'b0, 32'd1024, 32'hDEADBEEF);
        chk("wr ready trace", {26'h0, rec_ready[0], rec_ready[1], rec_ready[2], rec_ready[3],
                               rec_ready[4], rec_ready[5]}, 32'b000001);
        chk("wr we_n trace", {28'h0, rec_we[1], rec_we[2], rec_we[3], rec_we[4]}, 32'b0101);
        chk("wr addr lo", {14'h0, rec_addr[1]}, 32'd0);
        chk("wr addr hi", {14'h0, rec_addr[3]}, 32'd1);
        chk("wr dq lo",   {16'h0, rec_dq[1]}, 32'hBEEF);
        chk("wr dq hi",   {16'h0, rec_dq[3]}, 32'hDEAD);

        // Back-to-back read of 1028 (write request was held through DONE).
        run_access(1'b0, 1'b1, 32'd1028, 32'h0);
        chk("rd ready trace", {26'h0, rec_ready[0], rec_ready[1], rec_ready[2], rec_ready[3],
                               rec_ready[4], rec_ready[5]}, 32'b000001);
        chk("rd oe_n trace", {26'h0, rec_oe[0], rec_oe[1], rec_oe[2], rec_oe[3], rec_oe[4],
                              rec_oe[5]}, 32'b100001);
        chk("rd addr lo", {14'h0, rec_addr[1]}, 32'd2);
        chk("rd addr hi", {14'h0, rec_addr[3]}, 32'd3);
        chk("rd data done", rec_rd[5], 32'h12345678);

        // Write and read together: write wins.
        run_access(1'b1, 1'b1, 32'd1032, 32'hCAFEF00D);
        chk("both oe_n trace", {26'h0, rec_oe[0], rec_oe[1], rec_oe[2], rec_oe[3], rec_oe[4],
                                rec_oe[5]}, 32'b111111);
        chk("both rd_data held", rec_rd[5], 32'h12345678);
        go_idle(2);
        chk("mem[0]", {16'h0, mem[0]}, 32'hBEEF);
        chk("mem[1]", {16'h0, mem[1]}, 32'hDEAD);
        chk("mem[4]", {16'h0, mem[4]}, 32'hF00D);
        chk("mem[5]", {16'h0, mem[5]}, 32'hCAFE);
`ifdef SRAM_CTRL_STATS_EN
        chk("stat_accesses 3", stat_accesses, 32'd3);
        chk("stat_stall 15",   stat_stall_cycles, 32'd15);
`endif

        // Reset during the high half of a write at 1036.
        bus.wr_en = 1'b1; bus.address = 32'd1036; bus.st_val = 32'h11112222;
        repeat (4) @(negedge clk);
        #1 rst = 1'b1; bus.wr_en = 1'b0;
        #1;
        chk("abort we_n",  {31'h0, bus.sram_we_n},  32'h1);
        chk("abort dq_oe", {31'h0, bus.sram_dq_oe}, 32'h0);
        chk("abort ready", {31'h0, bus.ready},      32'h1);
        chk("abort addr",  {14'h0, bus.sram_addr},  32'h0);
        @(posedge clk); #1 rst = 1'b0;
        go_idle(1);
        chk("abort mem[6]", {16'h0, mem[6]}, 32'h2222);
        chk("abort mem[7]", {16'h0, mem[7]}, 32'h0);
`ifdef SRAM_CTRL_STATS_EN
        chk("stat_accesses rst", stat_accesses, 32'd0);
`endif
        run_access(1'b0, 1'b1, 32'd1036, 32'h0);
        chk("rd half-written", rec_rd[5], 32'h00002222);
        go_idle(2);
`ifdef SRAM_CTRL_STATS_EN
        chk("stat_accesses 1", stat_accesses, 32'd1);
        chk("stat_stall 5",    stat_stall_cycles, 32'd5);
`endif

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
